// File: rtl/sub_serial_pkg.sv
// Shared state encodings and sizing helper for the digit-serial subtract blocks.
// Reused by later subtract/ALU controllers that follow the same IDLE/RUN/DONE handshake.
package sub_serial_pkg;

  typedef enum logic [1:0] {
    SUB_IDLE = 2'd0,
    SUB_RUN  = 2'd1,
    SUB_DONE = 2'd2
  } sub_state_e;

  // Counter width for n digit steps; a single-step operation still needs one bit.
  function automatic int cnt_width(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/sub_digit.sv
// Combinational digit subtractor: o_d = i_x - i_y - i_bi, with borrow out.
// With SUB_OVF_EN defined it also exports the borrow into the top bit of the digit.
module sub_digit
  import sub_serial_pkg::*;
#(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] i_x,
  input  logic [DIGIT-1:0] i_y,
  input  logic             i_bi,
  output logic [DIGIT-1:0] o_d,
  output logic             o_bo
`ifdef SUB_OVF_EN
  ,
  output logic             o_bt
`endif
);

  logic [DIGIT:0] w_full;

  assign w_full = {1'b0, i_x} - {1'b0, i_y} - {{DIGIT{1'b0}}, i_bi};
  assign o_d    = w_full[DIGIT-1:0];
  assign o_bo   = w_full[DIGIT];

`ifdef SUB_OVF_EN
  // Top result bit is x^y^borrow_in, so the incoming borrow falls out of the sum bit.
  assign o_bt = w_full[DIGIT-1] ^ i_x[DIGIT-1] ^ i_y[DIGIT-1];
`endif

endmodule

// File: rtl/sub_serial.sv
// Digit-serial subtractor diff = a - b - bin, DIGIT bits per clock, LSB digit first.
// Optional signed overflow output is built only when SUB_OVF_EN is defined.
module sub_serial
  import sub_serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);

  sub_state_e       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_res, r_diff;
  logic             r_borrow, r_bout;
  logic [CW-1:0]    r_cnt;
  logic             w_accept, w_last, w_bo;
  logic [DIGIT-1:0] w_d;
  logic [WIDTH-1:0] w_res_nxt;
`ifdef SUB_OVF_EN
  logic             w_bt, r_ovf;
`endif

  assign w_accept = start && (r_state == SUB_IDLE || r_state == SUB_DONE);
  assign w_last   = (r_cnt == CW'(N - 1));

  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .i_x  (r_a[DIGIT-1:0]),
    .i_y  (r_b[DIGIT-1:0]),
    .i_bi (r_borrow),
    .o_d  (w_d),
    .o_bo (w_bo)
`ifdef SUB_OVF_EN
    ,
    .o_bt (w_bt)
`endif
  );

  // New digit enters at the MSB end; after N steps the LSB digit has reached bit 0.
  assign w_res_nxt = (r_res >> DIGIT) | (WIDTH'(w_d) << (WIDTH - DIGIT));

  always_ff @(posedge clk) begin
    if (rst) r_state <= SUB_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SUB_IDLE: if (start) w_state_nxt = SUB_RUN;
      SUB_RUN:  if (w_last) w_state_nxt = SUB_DONE;
      SUB_DONE: w_state_nxt = start ? SUB_RUN : SUB_IDLE;
      default:  w_state_nxt = SUB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_cnt    <= '0;
`ifdef SUB_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_borrow <= bin;
      r_cnt    <= '0;
    end else if (r_state == SUB_RUN) begin
      r_a      <= r_a >> DIGIT;
      r_b      <= r_b >> DIGIT;
      r_borrow <= w_bo;
      r_res    <= w_res_nxt;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        r_diff <= w_res_nxt;
        r_bout <= w_bo;
`ifdef SUB_OVF_EN
        r_ovf  <= w_bt ^ w_bo;
`endif
      end
    end
  end

  assign busy = (r_state == SUB_RUN);
  assign done = (r_state == SUB_DONE);
  assign diff = r_diff;
  assign bout = r_bout;
`ifdef SUB_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial: directed table, handshake corner cases, sweeps and random ops.
// Overflow checks are compiled in only when SUB_OVF_EN is defined.
module tb_sub_serial;

  logic        clk = 1'b0;
  logic        rst, start, bin;
  logic [7:0]  a, b;
  logic        busy, done, bout;
  logic [7:0]  diff;
`ifdef SUB_OVF_EN
  logic        ovf;
`endif

  logic        start4, start16, bin16;
  logic [15:0] a16, b16;
  logic        busy4, done4, bout4, busy16, done16, bout16;
  logic [15:0] diff4, diff16;
`ifdef SUB_OVF_EN
  logic        ovf4, ovf16;
`endif

  int n_cmp = 0, n_err = 0, n_start = 0, n_done = 0;

  always #5 clk = ~clk;

  sub_serial #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  sub_serial #(.WIDTH(16), .DIGIT(4)) dut16_4 (
    .clk(clk), .rst(rst), .start(start4), .a(a16), .b(b16), .bin(bin16),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
`ifdef SUB_OVF_EN
    , .ovf(ovf4)
`endif
  );

  sub_serial #(.WIDTH(16), .DIGIT(16)) dut16_16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .bin(bin16),
    .busy(busy16), .done(done16), .diff(diff16), .bout(bout16)
`ifdef SUB_OVF_EN
    , .ovf(ovf16)
`endif
  );

  always @(negedge clk) if (done === 1'b1) n_done++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the whole words.
  function automatic logic [8:0] model_sub(input logic [7:0] x, input logic [7:0] y, input logic c);
    int r;
    r = int'(x) - int'(y) - int'(c);
    return {(r < 0), r[7:0]};
  endfunction

  function automatic logic model_ovf(input logic [7:0] x, input logic [7:0] y, input logic c);
    int s;
    s = int'($signed(x)) - int'($signed(y)) - int'(c);
    return (s < -128) || (s > 127);
  endfunction

  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic c,
                       output logic [7:0] rd, output logic rb, output logic ro,
                       output int nb, output logic seen);
    int k;
    @(negedge clk);
    a = x; b = y; bin = c; start = 1'b1;
    n_start++;
    @(negedge clk);
    start = 1'b0;
    nb = 0;
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      if (busy === 1'b1) nb++;
      @(negedge clk);
      k++;
    end
    seen = (done === 1'b1);
    rd = diff;
    rb = bout;
`ifdef SUB_OVF_EN
    ro = ovf;
`else
    ro = 1'b0;
`endif
  endtask

  task automatic op16(input int sel, input logic [15:0] x, input logic [15:0] y, input logic c,
                      input logic [15:0] ed, input logic eb, input int en, input string nm);
    int k, nb;
    @(negedge clk);
    a16 = x; b16 = y; bin16 = c;
    if (sel == 0) start4 = 1'b1; else start16 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; start16 = 1'b0;
    nb = 0; k = 0;
    while (((sel == 0) ? done4 : done16) !== 1'b1 && k < 40) begin
      if (((sel == 0) ? busy4 : busy16) === 1'b1) nb++;
      @(negedge clk);
      k++;
    end
    check({nm, "_done_seen"}, 32'(k < 40), 32'd1);
    check({nm, "_busy_cycles"}, 32'(nb), 32'(en));
    check({nm, "_diff"}, 32'((sel == 0) ? diff4 : diff16), 32'(ed));
    check({nm, "_bout"}, 32'((sel == 0) ? bout4 : bout16), 32'(eb));
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [7:0] rd;
    logic       rb, ro, seen;
    logic [8:0] m;
    logic [7:0] rx, ry;
    logic       rc;
    int         nb, k, npulse;

    tbl[0] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[1] = '{8'h80, 8'h01, 1'b1, 8'h7E, 1'b0, 1'b1};
    tbl[2] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    tbl[3] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0};
    tbl[4] = '{8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0};
    tbl[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    tbl[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[7] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    start4 = 1'b0; start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
`ifdef SUB_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].c, rd, rb, ro, nb, seen);
      check($sformatf("tbl%0d_done_seen", i), 32'(seen), 32'd1);
      check($sformatf("tbl%0d_busy_cycles", i), 32'(nb), 32'd4);
      check($sformatf("tbl%0d_diff", i), 32'(rd), 32'(tbl[i].d));
      check($sformatf("tbl%0d_bout", i), 32'(rb), 32'(tbl[i].bo));
`ifdef SUB_OVF_EN
      check($sformatf("tbl%0d_ovf", i), 32'(ro), 32'(tbl[i].ov));
`endif
      @(negedge clk);
      check($sformatf("tbl%0d_done_one_cycle", i), 32'(done), 32'd0);
      check($sformatf("tbl%0d_diff_held", i), 32'(diff), 32'(tbl[i].d));
    end

    // start held through RUN with changing operands, then back-to-back accept on the done cycle
    @(negedge clk);
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    n_start++;
    k = 0;
    @(negedge clk);
    while (done !== 1'b1 && k < 20) begin
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      @(negedge clk);
      k++;
    end
    check("hold_done_seen", 32'(done), 32'd1);
    check("hold_diff", 32'(diff), 32'h02);
    check("hold_bout", 32'(bout), 32'd0);
    a = 8'h10; b = 8'h20; bin = 1'b0;
    n_start++;
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_gap_busy", 32'(busy), 32'd1);
    nb = 0; k = 0;
    while (done !== 1'b1 && k < 20) begin
      if (busy === 1'b1) nb++;
      @(negedge clk);
      k++;
    end
    check("b2b_busy_cycles", 32'(nb), 32'd4);
    check("b2b_diff", 32'(diff), 32'hF0);
    check("b2b_bout", 32'(bout), 32'd1);

    // Reset at the 2nd RUN edge aborts with no done pulse
    @(negedge clk);
    a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    npulse = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) npulse++;
    end
    check("abort_no_activity", 32'(npulse), 32'd0);

    // rst and start on the same edge: rst wins
    a = 8'h01; b = 8'h00; start = 1'b1; rst = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    check("rst_start_busy", 32'(busy), 32'd0);
    npulse = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done === 1'b1) npulse++;
    end
    check("rst_start_no_done", 32'(npulse), 32'd0);

    // Sweeps against the model
    for (int i = 0; i < 256; i++) begin
      rx = 8'(i);
      do_op(rx, 8'h01, 1'b0, rd, rb, ro, nb, seen);
      m = model_sub(rx, 8'h01, 1'b0);
      check($sformatf("sweepA_%0d", i), {22'd0, seen, rb, rd}, {22'd0, 1'b1, m});
`ifdef SUB_OVF_EN
      check($sformatf("sweepA_ovf_%0d", i), 32'(ro), 32'(model_ovf(rx, 8'h01, 1'b0)));
`endif
    end
    for (int c = 0; c < 2; c++) begin
      for (int i = 8'h80; i <= 8'hFF; i++) begin
        ry = 8'(i);
        rc = 1'(c);
        do_op(8'h80, ry, rc, rd, rb, ro, nb, seen);
        m = model_sub(8'h80, ry, rc);
        check($sformatf("sweepB_%0d_%0d", c, i), {22'd0, seen, rb, rd}, {22'd0, 1'b1, m});
`ifdef SUB_OVF_EN
        check($sformatf("sweepB_ovf_%0d_%0d", c, i), 32'(ro), 32'(model_ovf(8'h80, ry, rc)));
`endif
      end
    end

    // Random operations
    for (int i = 0; i < 60; i++) begin
      rx = 8'($urandom); ry = 8'($urandom); rc = 1'($urandom);
      do_op(rx, ry, rc, rd, rb, ro, nb, seen);
      m = model_sub(rx, ry, rc);
      check($sformatf("rand_%0d_%0h_%0h_%0d", i, rx, ry, rc), {14'd0, 8'(nb), seen, rb, rd},
            {14'd0, 8'd4, 1'b1, m});
`ifdef SUB_OVF_EN
      check($sformatf("rand_ovf_%0d", i), 32'(ro), 32'(model_ovf(rx, ry, rc)));
`endif
    end

    // Other geometries
    op16(0, 16'h1234, 16'h1235, 1'b0, 16'hFFFF, 1'b1, 4, "w16d4_a");
    op16(0, 16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 4, "w16d4_b");
    op16(1, 16'h1234, 16'h1235, 1'b0, 16'hFFFF, 1'b1, 1, "w16d16_a");
    op16(1, 16'h8000, 16'h0001, 1'b1, 16'h7FFE, 1'b0, 1, "w16d16_b");

    @(negedge clk);
    check("done_count_eq_start_count", 32'(n_done), 32'(n_start));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
